// File: rtl/itype_pkg.sv
// Shared constants for the I-type execute unit: funct3 codes, the SRAI funct7 pattern
// and the FSM state encoding.
package itype_pkg;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  localparam logic [6:0]  SRAI_FUNCT7      = 7'b0100000;
  // SRAI funct7 placed in imm12[11:5]; wider XLEN masks off the low bits that become shamt
  localparam logic [11:0] SRAI_IMM_PATTERN = {SRAI_FUNCT7, 5'b00000};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [2:0] funct3);
    return (funct3 == F3_SLLI) || (funct3 == F3_SRXI);
  endfunction

endpackage

// File: rtl/itype_alu_unit_shifter.sv
// Shifter for the I-type unit: one bit per cycle when ITYPE_SHIFT_ITER_EN is defined,
// otherwise a combinational barrel shifter whose done follows start.
module itype_shifter
  import itype_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir_right,
  input  logic               arith,
  output logic               done,
  output logic [XLEN-1:0]    result
);

`ifdef ITYPE_SHIFT_ITER_EN
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [XLEN-1:0]    val_q, val_d, step_val;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               right_q, right_d;
  logic               arith_q, arith_d;
  logic               active_q, active_d;

  always_comb begin
    if (right_q) step_val = {arith_q & val_q[XLEN-1], val_q[XLEN-1:1]};
    else         step_val = {val_q[XLEN-2:0], 1'b0};
  end

  // The last step is visible combinationally so the top can register it on the same edge.
  assign done   = active_q && (cnt_q == CNT_ONE);
  assign result = step_val;

  always_comb begin
    val_d    = val_q;
    cnt_d    = cnt_q;
    right_d  = right_q;
    arith_d  = arith_q;
    active_d = active_q;
    if (start) begin
      val_d    = operand;
      cnt_d    = shamt;
      right_d  = dir_right;
      arith_d  = arith;
      active_d = 1'b1;
    end else if (active_q) begin
      val_d = step_val;
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q    <= '0;
      cnt_q    <= '0;
      right_q  <= 1'b0;
      arith_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      val_q    <= val_d;
      cnt_q    <= cnt_d;
      right_q  <= right_d;
      arith_q  <= arith_d;
      active_q <= active_d;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    if (!dir_right)  result = operand << shamt;
    else if (arith)  result = $unsigned($signed(operand) >>> shamt);
    else             result = operand >> shamt;
  end

  assign done = start;
`endif

endmodule

// File: rtl/itype_alu_unit.sv
// I-type integer execute unit (ADDI..SRAI) with valid/ready on both sides and a registered
// writeback. Define ITYPE_SHIFT_ITER_EN for the iterative (1 bit/cycle) shifter.
module itype_alu_unit
  import itype_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN),
  parameter int RD_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [11:0]     in_imm12,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RD_W-1:0] out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            out_we,
  output logic            out_illegal,
  output logic            busy
);

  localparam logic [11:0] HI_MASK = 12'(12'hFFF << SHAMT_W);

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic               out_we_q, out_we_d;
  logic               out_illegal_q, out_illegal_d;
  logic [RD_W-1:0]    out_rd_q, out_rd_d;
  logic [XLEN-1:0]    out_result_q, out_result_d;

  logic [XLEN-1:0]    imm_ext, alu_result, shift_result;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift, is_arith, illegal, accept;
  logic               shift_start, shift_done;
  logic [11:0]        expected_hi;

  assign imm_ext  = {{(XLEN-12){in_imm12[11]}}, in_imm12};
  assign shamt    = in_imm12[SHAMT_W-1:0];
  assign is_shift = is_shift_op(in_funct3);
  assign is_arith = (in_funct3 == F3_SRXI) && in_imm12[10];

  // Bits above shamt must be all zero, or exactly the SRAI pattern for an arithmetic right shift.
  assign expected_hi = is_arith ? (SRAI_IMM_PATTERN & HI_MASK) : 12'h000;
  assign illegal     = is_shift && ((in_imm12 & HI_MASK) != expected_hi);

  always_comb begin
    alu_result = '0;
    case (in_funct3)
      F3_ADDI:  alu_result = in_rs1 + imm_ext;
      F3_SLTI:  alu_result = {{(XLEN-1){1'b0}}, $signed(in_rs1) < $signed(imm_ext)};
      F3_SLTIU: alu_result = {{(XLEN-1){1'b0}}, in_rs1 < imm_ext};
      F3_XORI:  alu_result = in_rs1 ^ imm_ext;
      F3_ORI:   alu_result = in_rs1 | imm_ext;
      F3_ANDI:  alu_result = in_rs1 & imm_ext;
      default:  alu_result = '0;
    endcase
  end

  itype_shifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .start     (shift_start),
    .operand   (in_rs1),
    .shamt     (shamt),
    .dir_right (in_funct3 == F3_SRXI),
    .arith     (is_arith),
    .done      (shift_done),
    .result    (shift_result)
  );

  // Accepting in DONE while the consumer drains gives back-to-back beats with no bubble.
  assign in_ready = (state_q != S_SHIFT) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    out_we_d      = out_we_q;
    out_illegal_d = out_illegal_q;
    out_rd_d      = out_rd_q;
    out_result_d  = out_result_q;
    shift_start   = 1'b0;

    case (state_q)
      S_SHIFT: begin
        if (shift_done) begin
          state_d      = S_DONE;
          out_valid_d  = 1'b1;
          out_result_d = shift_result;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      out_rd_d      = in_rd;
      out_illegal_d = illegal;
      out_we_d      = !illegal && (in_rd != '0);
      state_d       = S_DONE;
      out_valid_d   = 1'b1;
      if (illegal) begin
        out_result_d = '0;
      end else if (!is_shift) begin
        out_result_d = alu_result;
      end else begin
`ifdef ITYPE_SHIFT_ITER_EN
        if (shamt == '0) begin
          out_result_d = in_rs1;
        end else begin
          shift_start = 1'b1;
          state_d     = S_SHIFT;
          out_valid_d = 1'b0;
        end
`else
        out_result_d = shift_result;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      out_valid_q   <= 1'b0;
      out_we_q      <= 1'b0;
      out_illegal_q <= 1'b0;
      out_rd_q      <= '0;
      out_result_q  <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_we_q      <= out_we_d;
      out_illegal_q <= out_illegal_d;
      out_rd_q      <= out_rd_d;
      out_result_q  <= out_result_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_we      = out_we_q;
  assign out_illegal = out_illegal_q;
  assign out_rd      = out_rd_q;
  assign out_result  = out_result_q;
  assign busy        = (state_q != S_IDLE) || out_valid_q;

endmodule

// File: tb/tb_itype_alu_unit.sv
// Self-checking bench for itype_alu_unit: vector table, backpressure/reset sequences,
// random ops against a reference model, plus a 64-bit instance.
module tb_itype_alu_unit;

`ifdef ITYPE_SHIFT_ITER_EN
  localparam int ITER = 1;
`else
  localparam int ITER = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_funct3;
  logic [11:0] in_imm12;
  logic [31:0] in_rs1, out_result;
  logic [4:0]  in_rd, out_rd;
  logic        out_we, out_illegal, busy;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [2:0]  w_in_funct3;
  logic [11:0] w_in_imm12;
  logic [63:0] w_in_rs1, w_out_result;
  logic [4:0]  w_in_rd, w_out_rd;
  logic        w_out_we, w_out_illegal, w_busy;

  int pass_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  itype_alu_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_imm12(in_imm12), .in_rs1(in_rs1), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_result(out_result), .out_we(out_we), .out_illegal(out_illegal), .busy(busy)
  );

  itype_alu_unit #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_funct3(w_in_funct3), .in_imm12(w_in_imm12), .in_rs1(w_in_rs1), .in_rd(w_in_rd),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_rd(w_out_rd),
    .out_result(w_out_result), .out_we(w_out_we), .out_illegal(w_out_illegal), .busy(w_busy)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] rs1;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    logic        exp_we;
    logic        exp_ill;
    int          exp_lat;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic noteTimeout(input string name);
    check_cnt++;
    $display("[TB] FAIL %s: bound expired, actual=timeout required=handshake", name);
  endtask

  // Reference behaviour from the instruction semantics, using plain integer arithmetic.
  function automatic void refModel(input logic [2:0] f3, input logic [11:0] imm12,
                                   input logic [31:0] rs1, output logic [31:0] res,
                                   output logic ill, output int lat);
    int imm_v, shamt, f7;
    imm_v = int'(imm12);
    if (imm_v >= 2048) imm_v -= 4096;
    shamt = int'(imm12) % 32;
    f7    = int'(imm12) / 32;
    ill = 1'b0; lat = 1; res = '0;
    case (f3)
      3'd0: res = rs1 + 32'(imm_v);
      3'd2: res = (int'(rs1) < imm_v) ? 32'd1 : 32'd0;
      3'd3: res = (rs1 < 32'(imm_v)) ? 32'd1 : 32'd0;
      3'd4: res = rs1 ^ 32'(imm_v);
      3'd6: res = rs1 | 32'(imm_v);
      3'd7: res = rs1 & 32'(imm_v);
      3'd1: if (f7 != 0) ill = 1'b1; else res = rs1 << shamt;
      default: begin
        if (f7 == 0)       res = rs1 >> shamt;
        else if (f7 == 32) res = 32'(int'(rs1) >>> shamt);
        else               ill = 1'b1;
      end
    endcase
    if ((f3 == 3'd1 || f3 == 3'd5) && !ill && ITER == 1) lat = (shamt == 0) ? 1 : shamt + 1;
  endfunction

  task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] imm, input logic [31:0] rs1,
                               input logic [4:0] rd, output int lat, output bit ok);
    int n;
    in_funct3 = f3; in_imm12 = imm; in_rs1 = rs1; in_rd = rd; in_valid = 1'b1;
    n = 0; lat = 0; ok = 1'b0;
    while (!in_ready && n < 64) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      noteTimeout("in_ready wait");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_rs1 = $urandom; in_imm12 = 12'($urandom); in_funct3 = 3'($urandom); in_rd = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    ok = out_valid;
    if (!ok) noteTimeout("out_valid wait");
  endtask

  task automatic run64(input logic [2:0] f3, input logic [11:0] imm, input logic [63:0] rs1,
                       output logic [63:0] res, output logic ill);
    int n;
    w_in_funct3 = f3; w_in_imm12 = imm; w_in_rs1 = rs1; w_in_rd = 5'd7; w_in_valid = 1'b1;
    res = '0; ill = 1'b0; n = 0;
    while (!w_in_ready && n < 64) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    n = 0;
    while (!w_out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!w_out_valid) noteTimeout("xlen64 out_valid wait");
    res = w_out_result; ill = w_out_illegal;
    @(posedge clk); #1;
  endtask

  function automatic vec_t mkVec(input logic [2:0] f3, input logic [11:0] imm, input logic [31:0] rs1,
                                 input logic [4:0] rd, input logic [31:0] r, input logic we,
                                 input logic ill, input int lat);
    vec_t v;
    v.f3 = f3; v.imm = imm; v.rs1 = rs1; v.rd = rd;
    v.exp_res = r; v.exp_we = we; v.exp_ill = ill; v.exp_lat = lat;
    return v;
  endfunction

  initial begin
    int lat;
    bit ok;
    logic [31:0] m_res;
    logic        m_ill;
    int          m_lat;
    logic [63:0] r64;
    logic        i64;
    logic [11:0] imm;
    logic [2:0]  f3;
    logic [31:0] held;
    bit          seen;

    vecs[0]  = mkVec(3'd0, 12'h814, 32'd50, 5'd5, 32'hFFFFF846, 1'b1, 1'b0, 1);
    vecs[1]  = mkVec(3'd2, 12'h814, 32'd50, 5'd5, 32'h0, 1'b1, 1'b0, 1);
    vecs[2]  = mkVec(3'd3, 12'h814, 32'd50, 5'd6, 32'h1, 1'b1, 1'b0, 1);
    vecs[3]  = mkVec(3'd4, 12'h814, 32'd50, 5'd7, 32'hFFFFF826, 1'b1, 1'b0, 1);
    vecs[4]  = mkVec(3'd6, 12'h814, 32'd50, 5'd8, 32'hFFFFF836, 1'b1, 1'b0, 1);
    vecs[5]  = mkVec(3'd7, 12'h814, 32'd50, 5'd9, 32'h10, 1'b1, 1'b0, 1);
    vecs[6]  = mkVec(3'd1, 12'h003, 32'hFFFFF846, 5'd10, 32'hFFFFC230, 1'b1, 1'b0, ITER ? 4 : 1);
    vecs[7]  = mkVec(3'd5, 12'h003, 32'hFFFFF846, 5'd11, 32'h1FFFFF08, 1'b1, 1'b0, ITER ? 4 : 1);
    vecs[8]  = mkVec(3'd5, 12'h403, 32'hFFFFF846, 5'd12, 32'hFFFFFF08, 1'b1, 1'b0, ITER ? 4 : 1);
    vecs[9]  = mkVec(3'd1, 12'h023, 32'h12345678, 5'd13, 32'h0, 1'b0, 1'b1, 1);
    vecs[10] = mkVec(3'd0, 12'h001, 32'd7, 5'd0, 32'd8, 1'b0, 1'b0, 1);
    vecs[11] = mkVec(3'd5, 12'h400, 32'h80000000, 5'd14, 32'h80000000, 1'b1, 1'b0, 1);
    vecs[12] = mkVec(3'd5, 12'h01F, 32'h80000000, 5'd15, 32'h1, 1'b1, 1'b0, ITER ? 32 : 1);
    vecs[13] = mkVec(3'd2, 12'h000, 32'hFFFFFFFF, 5'd16, 32'h1, 1'b1, 1'b0, 1);
    vecs[14] = mkVec(3'd5, 12'h603, 32'hFFFFF846, 5'd17, 32'h0, 1'b0, 1'b1, 1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_funct3 = '0; in_imm12 = '0; in_rs1 = '0; in_rd = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1;
    w_in_funct3 = '0; w_in_imm12 = '0; w_in_rs1 = '0; w_in_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_we", out_we, 0);
    checkOutput("reset out_illegal", out_illegal, 0);
    checkOutput("reset out_result", out_result, 0);
    checkOutput("reset out_rd", out_rd, 0);
    checkOutput("reset busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle in_ready", in_ready, 1);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].f3, vecs[i].imm, vecs[i].rs1, vecs[i].rd, lat, ok);
      if (ok) begin
        checkOutput($sformatf("vec%0d result", i), out_result, vecs[i].exp_res);
        checkOutput($sformatf("vec%0d we", i), out_we, vecs[i].exp_we);
        checkOutput($sformatf("vec%0d illegal", i), out_illegal, vecs[i].exp_ill);
        checkOutput($sformatf("vec%0d rd", i), out_rd, vecs[i].rd);
        checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      end
    end

    // Backpressure: hold the beat, then drain and accept in the same cycle.
    @(posedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(3'd0, 12'h814, 32'd50, 5'd9, lat, ok);
    in_funct3 = 3'd0; in_imm12 = 12'h033; in_rs1 = 32'd100; in_rd = 5'd10; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checkOutput("bp hold valid", out_valid, 1);
      checkOutput("bp hold result", out_result, 32'hFFFFF846);
      checkOutput("bp hold rd", out_rd, 9);
      checkOutput("bp in_ready low", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp in_ready on drain", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("b2b valid", out_valid, 1);
    checkOutput("b2b result", out_result, 32'd151);
    checkOutput("b2b rd", out_rd, 10);
    @(posedge clk); #1;
    checkOutput("b2b drained", out_valid, 0);

    // Reset right after accepting a long shift: nothing may be written back.
    in_funct3 = 3'd1; in_imm12 = 12'h014; in_rs1 = 32'hA5A5A5A5; in_rd = 5'd3; in_valid = 1'b1;
    #1;
    checkOutput("shift accept ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("busy after shift accept", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst mid-op out_valid", out_valid, 0);
    checkOutput("rst mid-op busy", busy, 0);
    checkOutput("rst mid-op in_ready", in_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    checkOutput("rst mid-op no writeback", seen, 0);

    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom);
      imm = 12'($urandom);
      if ((f3 == 3'd1 || f3 == 3'd5) && ($urandom_range(0, 3) != 0))
        imm = {($urandom_range(0, 1) == 1 && f3 == 3'd5) ? 7'b0100000 : 7'b0000000, 5'($urandom)};
      held = $urandom;
      refModel(f3, imm, held, m_res, m_ill, m_lat);
      applyStimulus(f3, imm, held, 5'(i), lat, ok);
      if (ok) begin
        checkOutput($sformatf("rand%0d result", i), out_result, m_res);
        checkOutput($sformatf("rand%0d illegal", i), out_illegal, m_ill);
        checkOutput($sformatf("rand%0d we", i), out_we, !m_ill && (5'(i) != 5'd0));
        checkOutput($sformatf("rand%0d latency", i), lat, m_lat);
      end
    end
    @(posedge clk); #1;

    run64(3'd5, 12'h428, 64'h8000_0000_0000_0000, r64, i64);
    checkOutput("x64 srai 40", r64, 64'hFFFF_FFFF_FF80_0000);
    checkOutput("x64 srai legal", i64, 0);
    run64(3'd1, 12'h03F, 64'h1, r64, i64);
    checkOutput("x64 slli 63", r64, 64'h8000_0000_0000_0000);
    run64(3'd1, 12'h040, 64'h1, r64, i64);
    checkOutput("x64 slli bit6 illegal", i64, 1);
    run64(3'd0, 12'h001, 64'hFFFF_FFFF_FFFF_FFFF, r64, i64);
    checkOutput("x64 addi wrap", r64, 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
